load_store_unit: RTL and testbench

Data-side memory access sequencer for the multicycle RV64I core. It sits between the control unit and the bus/memory controller. On a start pulse it turns a load or store (funct3, byte address, rs2 value) into one aligned 64-bit bus transaction with lane byte-enables, and holds the request through the memory busy handshake. For loads it returns the extracted, sign/zero-extended result with a one-cycle done pulse; faulting accesses never reach the bus.

---
 rtl/load_store_unit_pkg.sv | 33 +++
 rtl/load_store_unit_align.sv | 56 +++++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared constants for the data-side load/store sequencer: funct3 width codes,
// FSM state encoding and the lane-mask helper.
package load_store_unit_pkg;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_DOUBLE = 3'b011;
    localparam logic [2:0] F3_BYTEU  = 3'b100;
    localparam logic [2:0] F3_HALFU  = 3'b101;
    localparam logic [2:0] F3_WORDU  = 3'b110;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'b00,
        LSU_ACCESS = 2'b01,
        LSU_WAIT   = 2'b10,
        LSU_DONE   = 2'b11
    } lsu_state_e;

    // Lane mask for an access of 1/2/4/8 bytes starting at lane 0.
    function automatic logic [7:0] base_mask(input logic [1:0] size_code);
        logic [7:0] mask;
        case (size_code)
            2'b00:   mask = 8'h01;
            2'b01:   mask = 8'h03;
            2'b10:   mask = 8'h0F;
            2'b11:   mask = 8'hFF;
            default: mask = 8'h00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: byte-enable generation, store data shift,
// load extraction with sign/zero extension, and access fault checks.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [2:0]  offset,
    input  logic [63:0] rs2_data,
    input  logic [63:0] rd_data,
    output logic [7:0]  byte_en,
    output logic [63:0] wr_data,
    output logic [63:0] rd_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic [5:0]  shamt_s;
    logic [63:0] rd_shift_s;

    assign shamt_s    = {offset, 3'b000};
    assign byte_en    = base_mask(funct3[1:0]) << offset;
    assign wr_data    = rs2_data << shamt_s;
    assign rd_shift_s = rd_data >> shamt_s;

    // Truncate the shifted doubleword to the access width and extend it.
    always_comb begin
        rd_ext = rd_shift_s;
        case (funct3)
            F3_BYTE:   rd_ext = {{56{rd_shift_s[7]}},  rd_shift_s[7:0]};
            F3_HALF:   rd_ext = {{48{rd_shift_s[15]}}, rd_shift_s[15:0]};
            F3_WORD:   rd_ext = {{32{rd_shift_s[31]}}, rd_shift_s[31:0]};
            F3_BYTEU:  rd_ext = {56'd0, rd_shift_s[7:0]};
            F3_HALFU:  rd_ext = {48'd0, rd_shift_s[15:0]};
            F3_WORDU:  rd_ext = {32'd0, rd_shift_s[31:0]};
            default:   rd_ext = rd_shift_s;
        endcase
    end

    // Fault checks; the top gives illegal priority over misaligned.
    always_comb begin
        misaligned = 1'b0;
        if (is_store) begin
            illegal = funct3[2];
        end else begin
            illegal = (funct3 == 3'b111);
        end
        case (funct3[1:0])
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = (offset[1:0] != 2'b00);
            2'b11:   misaligned = (offset != 3'b000);
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer: registers one request, drives a single aligned bus
// transaction through the busy handshake, and reports done/faults.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] rs2_data,
    output logic        done,
    output logic [63:0] load_data,
    output logic        fault_misaligned,
    output logic        fault_illegal,
    output logic        fault_timeout,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wr_data,
    output logic [7:0]  mem_byte_en,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    input  logic        mem_busy,
    input  logic [63:0] mem_rd_data
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       offset_r, funct3_r;
    logic             is_store_r;

    logic             idle_s, active_s, accept_s, finish_s, success_s, fault_s;
    logic             sel_store_s;
    logic [2:0]       sel_funct3_s, sel_offset_s;
    logic [7:0]       al_byte_en_s;
    logic [63:0]      al_wr_data_s, al_rd_ext_s;
    logic             al_misaligned_s, al_illegal_s;

    assign idle_s    = (state_r == LSU_IDLE);
    assign active_s  = (state_r == LSU_ACCESS) || (state_r == LSU_WAIT);
    assign accept_s  = idle_s && start;
    assign fault_s   = al_misaligned_s || al_illegal_s;
    assign success_s = (state_r == LSU_WAIT) && !mem_busy;
    assign finish_s  = active_s && (next_state_s == LSU_DONE);

    // Fault checks see the live request in IDLE, the captured one afterwards.
    assign sel_store_s  = idle_s ? is_store  : is_store_r;
    assign sel_funct3_s = idle_s ? funct3    : funct3_r;
    assign sel_offset_s = idle_s ? addr[2:0] : offset_r;

    lsu_align u_align (
        .is_store   (sel_store_s),
        .funct3     (sel_funct3_s),
        .offset     (sel_offset_s),
        .rs2_data   (rs2_data),
        .rd_data    (mem_rd_data),
        .byte_en    (al_byte_en_s),
        .wr_data    (al_wr_data_s),
        .rd_ext     (al_rd_ext_s),
        .misaligned (al_misaligned_s),
        .illegal    (al_illegal_s)
    );

    // Next-state logic; a busy fall wins over the timeout on the same edge.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            LSU_IDLE: begin
                if (start) begin
                    next_state_s = fault_s ? LSU_DONE : LSU_ACCESS;
                end else begin
                    next_state_s = LSU_IDLE;
                end
            end
            LSU_ACCESS: begin
                if (cnt_r == CNT_LAST) begin
                    next_state_s = LSU_DONE;
                end else if (mem_busy) begin
                    next_state_s = LSU_WAIT;
                end else begin
                    next_state_s = LSU_ACCESS;
                end
            end
            LSU_WAIT: begin
                if (!mem_busy || (cnt_r == CNT_LAST)) begin
                    next_state_s = LSU_DONE;
                end else begin
                    next_state_s = LSU_WAIT;
                end
            end
            LSU_DONE: next_state_s = LSU_IDLE;
            default:  next_state_s = LSU_IDLE;
        endcase
    end

    // State register, timeout counter and captured request fields.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= LSU_IDLE;
            cnt_r      <= '0;
            offset_r   <= 3'b000;
            funct3_r   <= 3'b000;
            is_store_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                cnt_r      <= '0;
                offset_r   <= addr[2:0];
                funct3_r   <= funct3;
                is_store_r <= is_store;
            end else if (active_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Registered outputs: bus request levels, done pulse, faults, load result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done             <= 1'b0;
            fault_misaligned <= 1'b0;
            fault_illegal    <= 1'b0;
            fault_timeout    <= 1'b0;
            load_data        <= 64'd0;
            mem_addr         <= 64'd0;
            mem_wr_data      <= 64'd0;
            mem_byte_en      <= 8'h00;
            mem_rd_en        <= 1'b0;
            mem_wr_en        <= 1'b0;
        end else begin
            done             <= (next_state_s == LSU_DONE);
            fault_illegal    <= accept_s && al_illegal_s;
            fault_misaligned <= accept_s && al_misaligned_s && !al_illegal_s;
            fault_timeout    <= finish_s && !success_s;
            if (accept_s && !fault_s) begin
                mem_addr    <= {addr[63:3], 3'b000};
                mem_wr_data <= al_wr_data_s;
                mem_byte_en <= al_byte_en_s;
                mem_rd_en   <= !is_store;
                mem_wr_en   <= is_store;
            end else if (finish_s) begin
                mem_byte_en <= 8'h00;
                mem_rd_en   <= 1'b0;
                mem_wr_en   <= 1'b0;
            end
            if (finish_s && success_s && !is_store_r) begin
                load_data <= al_rd_ext_s;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases from the access
// rules plus randomized transactions against an arithmetic reference model.
module tb_load_store_unit;

    localparam int TMO = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [63:0] addr = 64'd0;
    logic [63:0] rs2_data = 64'd0;
    logic        mem_busy = 1'b0;
    logic [63:0] mem_rd_data = 64'd0;
    logic        done, fault_misaligned, fault_illegal, fault_timeout;
    logic        mem_rd_en, mem_wr_en;
    logic [63:0] load_data, mem_addr, mem_wr_data;
    logic [7:0]  mem_byte_en;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [63:0] exp_load = 64'd0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .rs2_data(rs2_data), .done(done),
        .load_data(load_data), .fault_misaligned(fault_misaligned),
        .fault_illegal(fault_illegal), .fault_timeout(fault_timeout),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_byte_en(mem_byte_en),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_busy(mem_busy),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Reference model: access size in bytes and the rules derived from it.
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_illegal(input logic st, input logic [2:0] f3);
        return st ? (f3 >= 3'd4) : (f3 == 3'd7);
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input int off);
        return (off % m_size(f3)) != 0;
    endfunction

    function automatic logic [7:0] m_mask(input logic [2:0] f3, input int off);
        logic [15:0] m;
        m = ((16'd1 << m_size(f3)) - 16'd1) << off;
        return m[7:0];
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] f3, input int off, input logic [63:0] rd);
        int          bits;
        logic [63:0] v, keep;
        bits = 8 * m_size(f3);
        v = rd >> (8 * off);
        if (bits == 64) return v;
        keep = (64'd1 << bits) - 64'd1;
        v = v & keep;
        if (!f3[2] && v[bits-1]) v = v | ~keep;
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_rd_en"}, mem_rd_en, 1'b0);
        chk1({tag, "_wr_en"}, mem_wr_en, 1'b0);
        chk({tag, "_byte_en"}, 64'(mem_byte_en), 64'd0);
    endtask

    // One transaction; n_busy = cycles busy stays high (0 = never rises).
    task automatic do_access(input logic st, input logic [2:0] f3, input logic [63:0] a,
                             input logic [63:0] rs2, input logic [63:0] rd,
                             input int n_busy, input bit poke);
        int off;
        bit ill, mis, ok;
        int done_c;
        off = int'(a[2:0]);
        ill = m_illegal(st, f3);
        mis = m_misaligned(f3, off);
        ok = (n_busy >= 1) && (n_busy <= TMO - 1);
        done_c = ok ? n_busy + 1 : TMO;
        is_store = st; funct3 = f3; addr = a; rs2_data = rs2;
        mem_rd_data = rand64(); start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; is_store = ~st; funct3 = 3'($urandom); addr = rand64(); rs2_data = rand64();
        if (ill || mis) begin
            chk1("flt_done", done, 1'b1);
            chk1("flt_mis", fault_misaligned, mis && !ill);
            chk1("flt_ill", fault_illegal, ill);
            chk1("flt_tmo", fault_timeout, 1'b0);
            chk1("flt_rd_en", mem_rd_en, 1'b0);
            chk1("flt_wr_en", mem_wr_en, 1'b0);
            chk("flt_load_hold", load_data, exp_load);
            @(posedge clock); #1;
            check_idle_outputs("flt_after");
            return;
        end
        chk1("acc_rd_en", mem_rd_en, !st);
        chk1("acc_wr_en", mem_wr_en, st);
        chk("acc_byte_en", 64'(mem_byte_en), 64'(m_mask(f3, off)));
        chk("acc_addr", mem_addr, {a[63:3], 3'b000});
        if (st) chk("acc_wr_data", mem_wr_data, rs2 << (8 * off));
        chk1("acc_done", done, 1'b0);
        for (int c = 1; c <= done_c; c++) begin
            mem_busy = (c <= n_busy);
            mem_rd_data = (c == n_busy + 1) ? rd : rand64();
            if (poke && c == 2) begin
                start = 1'b1; is_store = ~st; funct3 = 3'($urandom); addr = rand64();
            end
            @(posedge clock); #1;
            start = 1'b0;
            if (c < done_c) begin
                chk1("wait_done", done, 1'b0);
                chk1("wait_rd_en", mem_rd_en, !st);
                chk1("wait_wr_en", mem_wr_en, st);
            end else begin
                chk1("end_done", done, 1'b1);
                chk1("end_tmo", fault_timeout, !ok);
                chk1("end_mis", fault_misaligned, 1'b0);
                chk1("end_ill", fault_illegal, 1'b0);
                chk1("end_rd_en", mem_rd_en, 1'b0);
                chk1("end_wr_en", mem_wr_en, 1'b0);
                if (ok && !st) exp_load = m_load(f3, off, rd);
                chk("end_load", load_data, exp_load);
            end
        end
        mem_busy = 1'b0;
        @(posedge clock); #1;
        check_idle_outputs("post");
    endtask

    initial begin
        logic        r_st;
        logic [2:0]  r_f3;
        logic [63:0] r_a;
        int          r_sel, r_n;

        repeat (3) @(posedge clock);
        #1;
        check_idle_outputs("rst");
        chk1("rst_mis", fault_misaligned, 1'b0);
        chk1("rst_ill", fault_illegal, 1'b0);
        chk1("rst_tmo", fault_timeout, 1'b0);
        chk("rst_load", load_data, 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_wr_data", mem_wr_data, 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Directed cases
        do_access(1'b0, 3'b010, 64'h104, 64'd0, 64'h8000_0001_0000_0000, 2, 1'b0);
        chk("lw_const", load_data, 64'hFFFF_FFFF_8000_0001);
        do_access(1'b1, 3'b001, 64'h006, 64'h1234, 64'd0, 1, 1'b0);
        do_access(1'b0, 3'b100, 64'h003, 64'd0, 64'h0000_0000_F100_0000, 1, 1'b0);
        chk("lbu_const", load_data, 64'h0000_0000_0000_00F1);
        do_access(1'b0, 3'b000, 64'h003, 64'd0, 64'h0000_0000_F100_0000, 3, 1'b0);
        chk("lb_const", load_data, 64'hFFFF_FFFF_FFFF_FFF1);
        do_access(1'b0, 3'b011, 64'h204, 64'd0, 64'd0, 1, 1'b0);
        do_access(1'b1, 3'b100, 64'h200, 64'h55, 64'd0, 1, 1'b0);
        do_access(1'b0, 3'b111, 64'h201, 64'd0, 64'd0, 1, 1'b0);
        do_access(1'b0, 3'b011, 64'h300, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 1'b0);
        chk("tmo_load_hold", load_data, 64'hFFFF_FFFF_FFFF_FFF1);
        do_access(1'b0, 3'b011, 64'h308, 64'd0, 64'h0123_4567_89AB_CDEF, TMO - 1, 1'b0);
        do_access(1'b1, 3'b011, 64'h310, 64'hDEAD, 64'd0, TMO, 1'b0);
        do_access(1'b0, 3'b110, 64'h404, 64'd0, 64'hFEDC_BA98_7654_3210, 3, 1'b1);

        // Reset in the middle of WAIT
        is_store = 1'b0; funct3 = 3'b010; addr = 64'h108; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; mem_busy = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk1("mid_rd_en", mem_rd_en, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_idle_outputs("arst");
        chk("arst_load", load_data, 64'd0);
        chk("arst_addr", mem_addr, 64'd0);
        exp_load = 64'd0;
        @(posedge clock); #1;
        chk1("arst_no_done", done, 1'b0);
        mem_busy = 1'b0; reset = 1'b1;
        @(posedge clock); #1;
        do_access(1'b0, 3'b010, 64'h104, 64'd0, 64'h8000_0001_0000_0000, 2, 1'b1);
        chk("lw_after_rst", load_data, 64'hFFFF_FFFF_8000_0001);

        // Randomized transactions
        for (int i = 0; i < 60; i++) begin
            r_st = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom);
            r_a = rand64();
            if ($urandom_range(0, 3) != 0) r_a = r_a & ~64'(m_size(r_f3) - 1);
            r_sel = $urandom_range(0, 9);
            if (r_sel < 7) r_n = $urandom_range(1, 4);
            else if (r_sel == 7) r_n = 0;
            else r_n = $urandom_range(13, 16);
            do_access(r_st, r_f3, r_a, rand64(), rand64(), r_n, bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
